// File: rtl/dp_result_reader_if.sv
// dp_result_reader_if: handshake bundle between the datapath REG stage, the
// result reader and the narrow downstream result bus.
//   x, z, in_valid, in_ready   : pair input (datapath -> reader)
//   out_data/valid/ready/tag/last : narrow beat stream (reader -> downstream)
//   count                      : FIFO occupancy, excluding the pair in flight
// Modports: slave = the reader itself, master = the environment around it.
interface dp_result_reader_if #(
  parameter int DATAWIDTH = 32,
  parameter int OUTWIDTH  = 16,
  parameter int DEPTH     = 4
);
  logic [DATAWIDTH-1:0]       x;
  logic [DATAWIDTH-1:0]       z;
  logic                       in_valid;
  logic                       in_ready;
  logic [OUTWIDTH-1:0]        out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_tag;
  logic                       out_last;
  logic [$clog2(DEPTH):0]     count;

  modport slave (
    input  x, z, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_tag, out_last, count
  );

  modport master (
    output x, z, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_tag, out_last, count
  );
endinterface

// File: rtl/dp_result_reader.sv
// dp_result_reader: buffers {x, z} result pairs in a DEPTH-entry FIFO and
// unpacks each pair into 2*DATAWIDTH/OUTWIDTH narrow beats, x LSB slice first
// through z MSB slice, with valid/ready backpressure on the beat side.
// Ports:
//   Clk  : rising-edge clock
//   Rst  : async active-low reset (asserts immediately, releases on Clk)
//   bus  : dp_result_reader_if.slave (pair input, beat output, count)
// All outputs are registered except in_ready, which is decoded from count.
module dp_result_reader #(
  parameter int DATAWIDTH = 32,
  parameter int OUTWIDTH  = 16,
  parameter int DEPTH     = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  dp_result_reader_if.slave     bus
);
  localparam int BEATS = 2 * DATAWIDTH / OUTWIDTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int IW    = $clog2(BEATS);
  localparam int PAIRW = 2 * DATAWIDTH;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [PAIRW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;

  state_t           r_state;
  logic [PAIRW-1:0] r_shift;
  logic [IW-1:0]    r_idx;
  logic [OUTWIDTH-1:0] r_data;
  logic             r_valid, r_tag, r_last;

  logic             w_in_ready, w_push, w_accept, w_pop;
  logic [PAIRW-1:0] w_head;
  logic [IW-1:0]    w_idx_nxt;

  // Deliberately no look-ahead on a same-cycle pop: a full FIFO refuses a
  // push even while the unpacker is draining it.
  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_accept   = r_valid && bus.out_ready;
  // Load a pair when idle, or right on acceptance of the last beat so
  // back-to-back pairs stream without a bubble.
  assign w_pop      = (r_count != '0) &&
                      ((r_state == S_IDLE) || (w_accept && r_last));
  assign w_head     = r_mem[r_rd_ptr];
  assign w_idx_nxt  = r_idx + 1'b1;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_tag   = r_tag;
  assign bus.out_last  = r_last;
  assign bus.count     = r_count;

  // Pair storage: z in the upper half so the LSB-first shift yields x first.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.z, bus.x};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Unpacker FSM with registered beat outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_tag   <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_pop) begin
      r_state <= S_SEND;
      r_valid <= 1'b1;
      r_idx   <= '0;
      r_data  <= w_head[OUTWIDTH-1:0];
      r_shift <= w_head >> OUTWIDTH;
      r_tag   <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      if (r_last) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_idx   <= w_idx_nxt;
        r_data  <= r_shift[OUTWIDTH-1:0];
        r_shift <= r_shift >> OUTWIDTH;
        r_tag   <= (w_idx_nxt >= IW'(BEATS / 2));
        r_last  <= (w_idx_nxt == IW'(BEATS - 1));
      end
    end
  end
endmodule

// File: doc/dp_result_reader.md
# dp_result_reader

Consumer-side endpoint for the registered result pair (x, z) produced by the generated 32-bit datapath modules. Accepts one {x, z} pair per valid/ready handshake and buffers pairs in a small FIFO. Unpacks each pair into a stream of narrow beats for a downstream reader with its own valid/ready backpressure. Sits directly after the datapath's output REG stage and decouples the datapath's issue rate from the narrow result bus.

## Interface

Parameters:
- DATAWIDTH, 32: width of each of x and z.
- OUTWIDTH, 16: beat width. DATAWIDTH must be an integer multiple of OUTWIDTH.
- DEPTH, 4: FIFO entries, each holding one {x, z} pair. Must be a power of 2, ≥ 2.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous reset, active-low. Asserts immediately; releases synchronously to Clk.
- x  input  DATAWIDTH  first result word.
- z  input  DATAWIDTH  second result word.
- in_valid  input  1  x/z valid this cycle.
- in_ready  output  1  FIFO can accept a pair.
- out_data  output  OUTWIDTH  current beat.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the beat.
- out_tag  output  1  0 = beat is a slice of x; 1 = beat is a slice of z.
- out_last  output  1  final beat of the pair.
- count  output  log2(DEPTH)+1  FIFO occupancy. Excludes the pair held in the unpacker.

## Operation

- Push: occurs when in_valid && in_ready; writes {x, z} at the write pointer.
  - in_ready = (count < DEPTH). It is combinational from count only and does not look ahead to a same-cycle pop.
  - A full FIFO therefore blocks a push even in a cycle that pops.
  - in_valid while in_ready=0 is ignored; no state changes.
- Pointers: wrap modulo DEPTH. count increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- Unpacker FSM, two states:
  - IDLE → LOAD_SEND when count > 0. This pops the head pair into the shift/hold register and sets beat index = 0.
  - SEND: out_valid=1. A beat is accepted when out_valid && out_ready; the index then advances.
  - On acceptance of the last beat: if count > 0 (evaluated before this cycle's push), pop the next pair and stay in SEND with index 0, giving no bubble. Otherwise go to IDLE.
- Beat order: B = 2·DATAWIDTH/OUTWIDTH beats per pair, defaults to 4.
  - Beat order is x least-significant slice first through x most-significant slice, then z least-significant through most-significant.
  - out_tag = 0 for the first B/2 beats and 1 for the rest. out_last = 1 only on beat B−1.
- Stability: while out_valid && !out_ready, out_data, out_tag and out_last hold their values.
- Reset mid-operation: the buffered pairs and the pair in flight are discarded. No partial-pair completion after reset release.

## Timing

- Reset values: out_valid=0, out_data=0, out_tag=0, out_last=0, count=0, pointers=0, FSM=IDLE. in_ready=1 whenever Rst is low, since it follows count.
- Latency: for a pair pushed at edge k into an empty FIFO with an IDLE unpacker, the pop occurs at edge k+1 and out_valid rises after edge k+1.
- With out_ready held high, one beat completes per cycle. Back-to-back pairs stream with no idle cycle between beat B−1 and the next beat 0.
- Throughput: the input sustains one pair per B cycles. The FIFO absorbs bursts of DEPTH pairs plus the one pair in the unpacker.
- All outputs are registered except in_ready.

## Test plan

- Reset: assert Rst=0 mid-stream with 3 pairs buffered → out_valid=0, count=0, in_ready=1 during reset. No stale beats after release.
- Single pair: push x=0x12345678, z=0x9ABCDEF0 at edge k, with out_ready=1 → out_valid rises after k+1. Beats are 0x5678, 0x1234, 0xDEF0, 0x9ABC; out_tag=0,0,1,1; out_last only on 0x9ABC. out_valid falls afterward.
- Fill/backpressure: out_ready=0; offer 6 distinct pairs continuously → 5 accepted (1 in unpacker, 4 in FIFO). count=4, in_ready=0, and the 6th pair is held at the input. Release out_ready → the 6th pair is accepted one cycle after count drops to 3. All 5 pairs emerge in order.
- Mid-pair stall: stream one pair; drop out_ready for 3 cycles after beat 1 → out_data stays 0x1234 with out_tag=0 and out_last=0 for all 3 cycles. The stream resumes with 0xDEF0.
- Back-to-back: push pairs (0xAAAA5555, 0x0F0F1E1E) and (0x00000001, 0xFFFFFFFF) on consecutive handshakes, with out_ready=1 → 8 consecutive valid beats with no gap. The last of pair 1 is 0x0F0F, then 0x0001 follows immediately.
- Wrap-around: push and drain 10 pairs with random out_ready → every pair is reproduced exactly across pointer wraps. count never exceeds 4 and never underflows.
